echo_effect: RTL and testbench

- Echo/delay pedal stage. Acts as the responder side of the board's START/DONE per-frame handshake.
- Accepts one 16-bit signed audio frame per handshake. Mixes it with an attenuated copy of the frame from D frames earlier. Writes the mixed result back into a circular delay line, which gives a decaying, repeating echo.
- Sits in the effect chain after tremolo. Driven by the board's frame sequencer exactly as the overdrive stage is.

---
 rtl/echo_effect.sv | 180 ++++++++++++++++++
 tb/tb_echo_effect.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/echo_effect.sv
// ---------------------------------------------------------------------------
// echo_effect
// Echo/delay pedal stage, responder side of the START/DONE frame handshake.
// Each accepted frame is mixed with an attenuated copy of the mixed frame
// from D frames earlier. The mixed result is written back into a circular
// delay line, which produces a decaying, repeating echo.
//
// Ports
//   CLK          : system clock, all state on rising edge
//   RESET_N      : asynchronous active-low reset
//   START        : frame request level from the initiator
//   input_frame  : signed sample, latched when a frame is accepted
//   time_sel     : delay select, 0 = DEPTH/2 frames, 1 = DEPTH-1 frames
//   DONE         : frame complete, held until START drops
//   output_frame : signed processed sample, updated once per frame
// ---------------------------------------------------------------------------
module echo_effect #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned FB_SHIFT = 1
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     START,
    input  logic signed [DATA_W-1:0] input_frame,
    input  logic                     time_sel,
    output logic                     DONE,
    output logic signed [DATA_W-1:0] output_frame
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] D_SHORT  = ADDR_W'(DEPTH / 2);
    localparam logic [ADDR_W-1:0] D_LONG   = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FILL_MAX = CNT_W'(DEPTH);

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Frame sequencer states
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_MIX   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    logic [2:0]               state_q, state_d;
    logic signed [DATA_W-1:0] in_q, in_d;
    logic                     tsel_q, tsel_d;
    logic [ADDR_W-1:0]        wptr_q, wptr_d;
    logic [CNT_W-1:0]         fill_q, fill_d;
    logic signed [DATA_W-1:0] mix_q, mix_d;
    logic signed [DATA_W-1:0] out_q, out_d;
    logic                     done_q, done_d;

    // Delay line: single-port, registered read, never cleared
    logic [DATA_W-1:0]        mem [DEPTH];
    logic signed [DATA_W-1:0] ram_q;

    logic [ADDR_W-1:0]        delay_c;
    logic [ADDR_W-1:0]        raddr_c;
    logic                     ram_we_c;
    logic                     ram_re_c;
    logic                     hist_valid_c;
    logic signed [DATA_W-1:0] delayed_c;
    logic signed [DATA_W-1:0] shifted_c;
    logic signed [DATA_W:0]   sum_c;
    logic signed [DATA_W-1:0] sat_c;

    // Delay length and tap address, wrapping modulo DEPTH
    always_comb begin
        delay_c = tsel_q ? D_LONG : D_SHORT;
        raddr_c = wptr_q - delay_c;
    end

    assign ram_we_c = (state_q == S_WRITE);
    assign ram_re_c = (state_q == S_READ);

    // RAM port: read and write never fall in the same cycle
    always_ff @(posedge CLK) begin
        if (ram_we_c) begin
            mem[wptr_q] <= mix_q;
        end
        if (ram_re_c) begin
            ram_q <= mem[raddr_c];
        end
    end

    // Feedback mix; taps older than the frames written since reset read as zero
    always_comb begin
        hist_valid_c = (fill_q >= CNT_W'(delay_c));
        delayed_c    = hist_valid_c ? ram_q : '0;
        shifted_c    = delayed_c >>> FB_SHIFT;
        sum_c        = {in_q[DATA_W-1], in_q} + {shifted_c[DATA_W-1], shifted_c};
        if (sum_c[DATA_W] != sum_c[DATA_W-1]) begin
            sat_c = sum_c[DATA_W] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_c = sum_c[DATA_W-1:0];
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        tsel_d  = tsel_q;
        wptr_d  = wptr_q;
        fill_d  = fill_q;
        mix_d   = mix_q;
        out_d   = out_q;
        done_d  = done_q;

        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (START) begin
                    in_d    = input_frame;
                    tsel_d  = time_sel;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_MIX;
            end
            S_MIX: begin
                mix_d   = sat_c;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                out_d  = mix_q;
                wptr_d = wptr_q + ADDR_W'(1);
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + CNT_W'(1);
                end
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // One frame per START period: wait here until START is seen low
                if (START) begin
                    done_d = 1'b1;
                end else begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            in_q    <= '0;
            tsel_q  <= 1'b0;
            wptr_q  <= '0;
            fill_q  <= '0;
            mix_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            tsel_q  <= tsel_d;
            wptr_q  <= wptr_d;
            fill_q  <= fill_d;
            mix_q   <= mix_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign DONE         = done_q;
    assign output_frame = out_q;

endmodule

// File: tb/tb_echo_effect.sv
// ---------------------------------------------------------------------------
// tb_echo_effect
// Self-checking bench for echo_effect (ADDR_W=4, so DEPTH=16, D=8 or 15).
// The reference keeps the full history of mixed frames since reset and
// derives each output from history[k-D]; expected DONE/output_frame timing
// is tracked by the driver and compared every cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_echo_effect;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int FB_SHIFT = 1;
    localparam int DEPTH    = 16;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic signed [DATA_W-1:0] in_f;
    logic                     time_sel;
    logic                     done;
    logic signed [DATA_W-1:0] out_f;

    int errors = 0;
    int checks = 0;

    int hist[$];
    int exp_out  = 0;
    int exp_done = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    echo_effect #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .FB_SHIFT(FB_SHIFT)
    ) dut (
        .CLK         (clk),
        .RESET_N     (rst_n),
        .START       (start),
        .input_frame (in_f),
        .time_sel    (time_sel),
        .DONE        (done),
        .output_frame(out_f)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Every-cycle comparison against the tracked expectation
    always @(negedge clk) begin
        if (chk_en) begin
            check("done", int'(done), exp_done);
            check("output_frame", int'(out_f), exp_out);
        end
    end

    // Reference: echo of the mixed frame D frames back, halved, saturated
    function automatic int model_step(input int x, input bit ts);
        int d;
        int k;
        int delayed;
        int s;
        d = ts ? DEPTH - 1 : DEPTH / 2;
        k = hist.size();
        delayed = (k >= d) ? hist[k - d] : 0;
        s = x + (delayed >>> FB_SHIFT);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        hist.push_back(s);
        return s;
    endfunction

    function automatic int rand_sample();
        logic signed [DATA_W-1:0] v;
        if ($urandom_range(0, 1) == 1) begin
            return int'($urandom_range(0, 2000)) - 1000;
        end
        v = DATA_W'($urandom);
        return int'(v);
    endfunction

    // One full handshake; hold = extra cycles START stays high after DONE
    task automatic do_frame(input int x, input bit ts, input int hold,
                            input bit scramble, output int res);
        @(negedge clk);
        start    = 1'b1;
        in_f     = DATA_W'(x);
        time_sel = ts;
        res      = model_step(x, ts);
        @(posedge clk); #1;
        if (scramble) begin
            in_f     = DATA_W'($urandom);
            time_sel = ~ts;
        end
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        exp_out = res;
        @(posedge clk); #1;
        exp_done = 1;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        exp_done = 0;
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_done", int'(done), 0);
        check("rst_async_out", int'(out_f), 0);
        hist.delete();
        exp_out  = 0;
        exp_done = 0;
        start    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Start a frame and reset n edges after acceptance
    task automatic abort_frame(input int x, input bit ts, input int n);
        int res;
        @(negedge clk);
        start    = 1'b1;
        in_f     = DATA_W'(x);
        time_sel = ts;
        res      = model_step(x, ts);
        @(posedge clk); #1;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            if (i == 3) exp_out = res;
            if (i >= 4) exp_done = 1;
        end
        apply_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int x;
        int vals[15];

        rst_n    = 1'b0;
        start    = 1'b0;
        in_f     = '0;
        time_sel = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_done", int'(done), 0);
        check("reset_out", int'(out_f), 0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        repeat (5) @(negedge clk);

        // Long START: DONE rises 4 edges after acceptance, held while START high
        do_frame(1234, 1'b0, 7, 1'b0, r);
        check("handshake_out", int'(out_f), 1234);
        repeat (3) @(negedge clk);

        // Impulse response at D=8
        apply_reset();
        do_frame(1000, 1'b0, 0, 1'b0, r);
        check("impulse0", int'(out_f), 1000);
        for (int i = 1; i <= 24; i++) begin
            do_frame(0, 1'b0, int'($urandom_range(0, 2)), 1'b0, r);
            if (i == 8)  check("impulse8", int'(out_f), 500);
            if (i == 16) check("impulse16", int'(out_f), 250);
            if (i == 24) check("impulse24", int'(out_f), 125);
        end

        // Positive and negative saturation
        apply_reset();
        do_frame(10000, 1'b0, 0, 1'b0, r);
        for (int i = 0; i < 7; i++) do_frame(0, 1'b0, 0, 1'b0, r);
        do_frame(30000, 1'b0, 0, 1'b0, r);
        check("sat_pos", int'(out_f), 32767);
        apply_reset();
        do_frame(-10000, 1'b0, 0, 1'b0, r);
        for (int i = 0; i < 7; i++) do_frame(0, 1'b0, 0, 1'b0, r);
        do_frame(-30000, 1'b0, 0, 1'b0, r);
        check("sat_neg", int'(out_f), -32768);

        // Fill guard at D=15, then reset mid-frame and refeed over stale RAM
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            x = 100 + 7 * i;
            do_frame(x, 1'b1, 0, 1'b0, r);
            if (i == 14) check("fill_last_dry", int'(out_f), 198);
            if (i == 15) check("fill_first_wet", int'(out_f), 205 + 50);
        end
        abort_frame(4444, 1'b1, 1);
        for (int i = 0; i < 15; i++) begin
            vals[i] = 3000 - 111 * i;
            do_frame(vals[i], 1'b1, 0, 1'b0, r);
            check("stale_ignored", int'(out_f), vals[i]);
        end

        // Inputs changed right after acceptance must not affect the frame
        apply_reset();
        do_frame(500, 1'b0, 1, 1'b1, r);
        check("sampling", int'(out_f), 500);
        for (int i = 0; i < 8; i++) do_frame(-20 * i, 1'b0, 0, 1'b1, r);

        // Randomized traffic with occasional aborts
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                abort_frame(rand_sample(), 1'($urandom_range(0, 1)),
                            int'($urandom_range(0, 6)));
            end else begin
                do_frame(rand_sample(), 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
